// File: rtl/cuckoo_clock.sv
// Time-of-day core: BCD hours/minutes, blinking colon, push-button time setting.
// Define CUCKOO_CLOCK_12H_EN for a 12-hour display (12,01..11); default is 24-hour.
module cuckoo_clock (
    input  logic       clk10hz,
    input  logic       rst_n,
    input  logic       minClkRate,
    input  logic       hourClkRate,
    input  logic       setButton,
    input  logic       setM,
    input  logic       setH,
    output logic [3:0] hourTens,
    output logic [3:0] hourMu,
    output logic [3:0] minTens,
    output logic [3:0] minMu,
    output logic       colon
);

`ifdef CUCKOO_CLOCK_12H_EN
    localparam logic [3:0] RST_HOUR_TENS = 4'd1;
    localparam logic [3:0] RST_HOUR_MU   = 4'd2;
`else
    localparam logic [3:0] RST_HOUR_TENS = 4'd0;
    localparam logic [3:0] RST_HOUR_MU   = 4'd0;
`endif

    logic       runMode;
    logic       minStep;
    logic       hourStep;
    logic       minAt59;
    logic [3:0] blinkCnt;
    logic [3:0] blinkCntNext;
    logic [3:0] minTensNext;
    logic [3:0] minMuNext;
    logic [3:0] hourTensNext;
    logic [3:0] hourMuNext;
    logic       colonNext;

    // In set mode the minute field never carries into hours.
    assign runMode  = setButton;
    assign minAt59  = (minTens == 4'd5) && (minMu == 4'd9);
    assign minStep  = runMode ? minClkRate : (hourClkRate & ~setM);
    assign hourStep = runMode ? (minClkRate & minAt59) : (hourClkRate & ~setH);

    always_comb begin
        minTensNext = minTens;
        minMuNext   = minMu;
        if (minStep) begin
            if (minMu == 4'd9) begin
                minMuNext   = 4'd0;
                minTensNext = (minTens == 4'd5) ? 4'd0 : minTens + 4'd1;
            end else begin
                minMuNext = minMu + 4'd1;
            end
        end
    end

    always_comb begin
        hourTensNext = hourTens;
        hourMuNext   = hourMu;
        if (hourStep) begin
`ifdef CUCKOO_CLOCK_12H_EN
            if (hourTens == 4'd1 && hourMu == 4'd2) begin
                hourTensNext = 4'd0;
                hourMuNext   = 4'd1;
            end
`else
            if (hourTens == 4'd2 && hourMu == 4'd3) begin
                hourTensNext = 4'd0;
                hourMuNext   = 4'd0;
            end
`endif
            else if (hourMu == 4'd9) begin
                hourTensNext = hourTens + 4'd1;
                hourMuNext   = 4'd0;
            end else begin
                hourMuNext = hourMu + 4'd1;
            end
        end
    end

    // Blink counter free-runs in both modes; colon is forced on while setting.
    always_comb begin
        blinkCntNext = (blinkCnt == 4'd9) ? 4'd0 : blinkCnt + 4'd1;
        colonNext    = runMode ? (blinkCntNext < 4'd5) : 1'b1;
    end

    always_ff @(posedge clk10hz) begin
        if (!rst_n) begin
            hourTens <= RST_HOUR_TENS;
            hourMu   <= RST_HOUR_MU;
            minTens  <= 4'd0;
            minMu    <= 4'd0;
            blinkCnt <= 4'd0;
            colon    <= 1'b1;
        end else begin
            hourTens <= hourTensNext;
            hourMu   <= hourMuNext;
            minTens  <= minTensNext;
            minMu    <= minMuNext;
            blinkCnt <= blinkCntNext;
            colon    <= colonNext;
        end
    end

endmodule

// File: tb/tb_cuckoo_clock.sv
// Directed self-checking bench for cuckoo_clock; time compared as 16'hHHMM BCD.
// Follows CUCKOO_CLOCK_12H_EN to select the 12-hour or 24-hour vectors.
module tb_cuckoo_clock;

    logic       clk10hz = 1'b0;
    logic       rst_n;
    logic       minClkRate;
    logic       hourClkRate;
    logic       setButton;
    logic       setM;
    logic       setH;
    logic [3:0] hourTens;
    logic [3:0] hourMu;
    logic [3:0] minTens;
    logic [3:0] minMu;
    logic       colon;

    int checks = 0;
    int errors = 0;
    logic [15:0] expQ[$];

`ifdef CUCKOO_CLOCK_12H_EN
    localparam logic [15:0] RST_TIME = 16'h1200;
`else
    localparam logic [15:0] RST_TIME = 16'h0000;
`endif

    cuckoo_clock dut (
        .clk10hz    (clk10hz),
        .rst_n      (rst_n),
        .minClkRate (minClkRate),
        .hourClkRate(hourClkRate),
        .setButton  (setButton),
        .setM       (setM),
        .setH       (setH),
        .hourTens   (hourTens),
        .hourMu     (hourMu),
        .minTens    (minTens),
        .minMu      (minMu),
        .colon      (colon)
    );

    always #5 clk10hz = ~clk10hz;

    function automatic logic [15:0] curTime();
        return {hourTens, hourMu, minTens, minMu};
    endfunction

    task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk10hz);
        #1;
    endtask

    task automatic minPulses(input int n);
        for (int i = 0; i < n; i++) begin
            minClkRate = 1'b1;
            step();
            minClkRate = 1'b0;
            step();
        end
    endtask

    task automatic setTicks(input int n);
        for (int i = 0; i < n; i++) begin
            hourClkRate = 1'b1;
            step();
            hourClkRate = 1'b0;
            step();
        end
    endtask

    task automatic doReset();
        rst_n       = 1'b0;
        minClkRate  = 1'b0;
        hourClkRate = 1'b0;
        setButton   = 1'b1;
        setM        = 1'b1;
        setH        = 1'b1;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        minClkRate  = 1'b0;
        hourClkRate = 1'b0;
        setButton   = 1'b1;
        setM        = 1'b1;
        setH        = 1'b1;
        step();
        checkVal("rst_time", curTime(), RST_TIME);
        checkVal("rst_colon", {15'd0, colon}, 16'd1);
        rst_n = 1'b1;

        // Colon blink after release: low on edges 5..9, high again on edge 10.
        for (int k = 1; k <= 10; k++) expQ.push_back(((k % 10) < 5) ? 16'd1 : 16'd0);
        for (int k = 1; k <= 10; k++) begin
            logic [15:0] e;
            step();
            e = expQ.pop_front();
            checkVal($sformatf("blink_%0d", k), {15'd0, colon}, e);
        end
        checkVal("idle_hold", curTime(), RST_TIME);

`ifdef CUCKOO_CLOCK_12H_EN
        minPulses(60);
        checkVal("h12_carry", curTime(), 16'h0100);
        setButton = 1'b0;
        setH = 1'b0;
        setTicks(10);
        checkVal("h12_set_11", curTime(), 16'h1100);
        setH = 1'b1;
        setM = 1'b0;
        setTicks(59);
        checkVal("h12_set_1159", curTime(), 16'h1159);
        setM = 1'b1;
        setButton = 1'b1;
        minPulses(1);
        checkVal("h12_11_to_12", curTime(), 16'h1200);
        setButton = 1'b0;
        setH = 1'b0;
        setTicks(1);
        checkVal("h12_12_to_01", curTime(), 16'h0100);
        setH = 1'b1;
        setButton = 1'b1;
`else
        minPulses(10);
        checkVal("min_tens_carry", curTime(), 16'h0010);
        minPulses(50);
        checkVal("hour_carry", curTime(), 16'h0100);

        doReset();
        minClkRate = 1'b1;
        step(); step(); step();
        minClkRate = 1'b0;
        checkVal("held_tick", curTime(), 16'h0003);

        doReset();
        setButton = 1'b0;
        setH = 1'b0;
        setTicks(25);
        checkVal("set_hours_wrap", curTime(), 16'h0100);
        checkVal("set_colon", {15'd0, colon}, 16'd1);
        setTicks(22);
        checkVal("set_hours_23", curTime(), 16'h2300);
        setH = 1'b1;
        setM = 1'b0;
        setTicks(59);
        checkVal("set_2359", curTime(), 16'h2359);
        minPulses(1);
        checkVal("min_ignored_set", curTime(), 16'h2359);
        setM = 1'b1;
        setButton = 1'b1;
        minPulses(1);
        checkVal("day_wrap", curTime(), 16'h0000);

        doReset();
        setButton = 1'b0;
        setM = 1'b0;
        setTicks(61);
        checkVal("set_min_no_carry", curTime(), 16'h0001);
        checkVal("set_min_colon", {15'd0, colon}, 16'd1);

        doReset();
        setButton = 1'b0;
        setM = 1'b0;
        setH = 1'b0;
        setTicks(1);
        checkVal("set_both", curTime(), 16'h0101);
        setButton = 1'b1;
        hourClkRate = 1'b1;
        step();
        hourClkRate = 1'b0;
        checkVal("set_ignored_run", curTime(), 16'h0101);
        setM = 1'b1;
        setH = 1'b1;

        doReset();
        setButton = 1'b0;
        setH = 1'b0;
        setTicks(12);
        setH = 1'b1;
        setM = 1'b0;
        setTicks(34);
        setM = 1'b1;
        setButton = 1'b1;
        checkVal("reach_1234", curTime(), 16'h1234);
        rst_n = 1'b0;
        minClkRate = 1'b1;
        step();
        minClkRate = 1'b0;
        rst_n = 1'b1;
        checkVal("mid_reset_time", curTime(), 16'h0000);
        checkVal("mid_reset_colon", {15'd0, colon}, 16'd1);
`endif

        // Counter keeps running through set mode: back in run mode at count 5 colon drops.
        doReset();
        setButton = 1'b0;
        step(); step(); step();
        checkVal("set_steady_colon", {15'd0, colon}, 16'd1);
        setButton = 1'b1;
        step();
        checkVal("resume_cnt4", {15'd0, colon}, 16'd1);
        step();
        checkVal("resume_cnt5", {15'd0, colon}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
